// File: rtl/mem_access_if.sv
// mem_access_if: request/acknowledge bus between the load/store unit and data memory.
interface mem_access_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_data_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
      input  mem_ack_i, mem_data_i
   );
   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
      output mem_ack_i, mem_data_i
   );
endinterface

// File: rtl/mem_access.sv
// mem_access: MIPS memory-stage load/store unit with req/ack bus, stall request and load formatting.
module mem_access #(
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          aluop_i,
   input  logic [31:0]         mem_addr_i,
   input  logic [31:0]         reg2_i,
   input  logic [4:0]          wd_i,
   input  logic                wreg_i,
   input  logic [31:0]         wdata_i,
   mem_access_if.master        bus,
   output logic [4:0]          wd_o,
   output logic                wreg_o,
   output logic [31:0]         wdata_o,
   output logic                stallreq_o,
   output logic                align_err_o,
   output logic                bus_err_o
);
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
   state_t r_state, w_next;

   logic [CW-1:0] r_cnt;
   logic [31:0]   r_rdata, r_addr, r_data;
   logic [3:0]    r_sel;
   logic          r_req, r_we, r_err;

   logic        w_ld, w_st, w_byte, w_half, w_word, w_sext, w_misal, w_go, w_ack, w_tmo;
   logic [1:0]  w_off;
   logic [3:0]  w_sel;
   logic [7:0]  w_bval;
   logic [15:0] w_hval;
   logic [31:0] w_sdata, w_ldata;

   assign w_ld    = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
   assign w_st    = aluop_i inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
   assign w_byte  = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
   assign w_half  = aluop_i inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
   assign w_word  = aluop_i inside {EXE_LW_OP, EXE_SW_OP};
   assign w_sext  = aluop_i inside {EXE_LB_OP, EXE_LH_OP};
   assign w_off   = mem_addr_i[1:0];
   assign w_misal = (w_half & w_off[0]) | (w_word & |w_off);
   assign w_go    = (w_ld | w_st) & ~w_misal;
   assign w_ack   = bus.mem_ack_i;
   assign w_tmo   = r_cnt == CW'(TIMEOUT - 1);

   // Big-endian lanes: offset 00 is the most significant byte.
   assign w_sel   = w_word ? 4'b1111 : w_half ? (w_off[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> w_off;
   assign w_sdata = w_byte ? {4{reg2_i[7:0]}} : w_half ? {2{reg2_i[15:0]}} : reg2_i;
   assign w_bval  = 8'(r_rdata >> {~w_off, 3'b000});
   assign w_hval  = w_off[1] ? r_rdata[15:0] : r_rdata[31:16];
   assign w_ldata = w_byte ? {{24{w_sext & w_bval[7]}}, w_bval}
                  : w_half ? {{16{w_sext & w_hval[15]}}, w_hval} : r_rdata;

   assign bus.mem_req_o  = r_req;
   assign bus.mem_we_o   = r_we;
   assign bus.mem_addr_o = r_addr;
   assign bus.mem_sel_o  = r_sel;
   assign bus.mem_data_o = r_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      wd_o        = wd_i;
      wreg_o      = 1'b0;
      wdata_o     = wdata_i;
      stallreq_o  = 1'b0;
      align_err_o = 1'b0;
      bus_err_o   = 1'b0;
      case (r_state)
         S_IDLE: begin
            wreg_o      = wreg_i & ~(w_ld | w_st);
            align_err_o = w_misal;
            stallreq_o  = w_go;
            w_next      = w_go ? S_REQ : S_IDLE;
         end
         S_REQ: begin
            stallreq_o = 1'b1;
            w_next     = (w_ack | w_tmo) ? S_DONE : S_REQ;
         end
         S_DONE: begin
            wreg_o    = wreg_i & w_ld & ~r_err;
            wdata_o   = w_ld ? w_ldata : wdata_i;
            bus_err_o = r_err;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (!rst) begin
         wd_o        = '0;
         wreg_o      = 1'b0;
         wdata_o     = '0;
         stallreq_o  = 1'b0;
         align_err_o = 1'b0;
         bus_err_o   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_sel   <= '0;
         r_data  <= '0;
      end else if (r_state == S_IDLE && w_go) begin
         r_cnt  <= '0;
         r_err  <= 1'b0;
         r_req  <= 1'b1;
         r_we   <= w_st;
         r_addr <= {mem_addr_i[31:2], 2'b00};
         r_sel  <= w_sel;
         r_data <= w_sdata;
      end else if (r_state == S_REQ) begin
         r_cnt <= r_cnt + CW'(1);
         r_err <= ~w_ack & w_tmo;
         if (w_ack) r_rdata <= bus.mem_data_i;
         if (w_ack | w_tmo) r_req <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors for the memory-stage load/store unit.
module tb_mem_access;
   localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop;
   logic [31:0] addr, reg2, wdata_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [4:0]  wd_o;
   logic        wreg_o, stallreq_o, align_err_o, bus_err_o;
   logic [31:0] wdata_o;

   int n_tot = 0;
   int n_bad = 0;
   int s_stalls, s_reqs;
   logic [3:0]  s_sel;
   logic [31:0] s_addr, s_data;
   logic        s_we;

   mem_access_if bus_if ();

   mem_access #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .aluop_i(aluop), .mem_addr_i(addr), .reg2_i(reg2),
      .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .bus(bus_if),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
      .align_err_o(align_err_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2);
      aluop   = op;
      addr    = a;
      reg2    = r2;
      wreg_i  = 1'b1;
      wd_i    = 5'd9;
      wdata_i = 32'h0000_0077;
   endtask

   // Runs an already-presented memory op until stall drops; ack arrives in REQ cycle wait_n.
   task automatic run_mem(input int wait_n, input logic [31:0] rdata);
      s_stalls = 0;
      s_reqs   = 0;
      for (int c = 0; c < 40; c++) begin
         bus_if.mem_ack_i  = (c == wait_n + 1);
         bus_if.mem_data_i = (c == wait_n + 1) ? rdata : 32'hDEAD_BEEF;
         #1;
         if (!stallreq_o) break;
         s_stalls++;
         if (bus_if.mem_req_o) s_reqs++;
         if (c == 1) begin
            s_sel  = bus_if.mem_sel_o;
            s_addr = bus_if.mem_addr_o;
            s_data = bus_if.mem_data_o;
            s_we   = bus_if.mem_we_o;
         end
         @(posedge clk);
         #1;
      end
      bus_if.mem_ack_i = 1'b0;
      if (s_stalls >= 39) chk("stall_bound", 32'(s_stalls), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      bus_if.mem_ack_i  = 1'b0;
      bus_if.mem_data_i = '0;
      set_op(EXE_OR_OP, 32'h0, 32'h0);
      wdata_i = 32'h55;
      tick();
      tick();
      #1;
      chk("rst_req", 32'(bus_if.mem_req_o), 32'd0);
      chk("rst_addr", bus_if.mem_addr_o, 32'd0);
      chk("rst_stall", 32'(stallreq_o), 32'd0);
      chk("rst_wreg", 32'(wreg_o), 32'd0);
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_wd", 32'(wd_o), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      set_op(EXE_OR_OP, 32'h0, 32'h0);
      wdata_i = 32'h1234;
      #1;
      chk("nop_wreg", 32'(wreg_o), 32'd1);
      chk("nop_wdata", wdata_o, 32'h1234);
      chk("nop_wd", 32'(wd_o), 32'd9);
      chk("nop_stall", 32'(stallreq_o), 32'd0);
      tick();
      chk("nop_req", 32'(bus_if.mem_req_o), 32'd0);

      set_op(EXE_LB_OP, 32'h1001, 32'h0);
      run_mem(2, 32'h11F2_3344);
      chk("lb_stalls", 32'(s_stalls), 32'd4);
      chk("lb_sel", 32'(s_sel), 32'b0100);
      chk("lb_addr", s_addr, 32'h1000);
      chk("lb_we", 32'(s_we), 32'd0);
      chk("lb_wdata", wdata_o, 32'hFFFF_FFF2);
      chk("lb_wreg", 32'(wreg_o), 32'd1);
      chk("lb_req_done", 32'(bus_if.mem_req_o), 32'd0);
      tick();

      set_op(EXE_LBU_OP, 32'h1001, 32'h0);
      run_mem(2, 32'h11F2_3344);
      chk("lbu_wdata", wdata_o, 32'h0000_00F2);
      tick();

      set_op(EXE_SH_OP, 32'h2002, 32'hAAAA_5678);
      run_mem(0, 32'h0);
      chk("sh_stalls", 32'(s_stalls), 32'd2);
      chk("sh_we", 32'(s_we), 32'd1);
      chk("sh_sel", 32'(s_sel), 32'b0011);
      chk("sh_data", s_data, 32'h5678_5678);
      chk("sh_wreg", 32'(wreg_o), 32'd0);
      tick();

      set_op(EXE_SB_OP, 32'h6003, 32'h0000_00AB);
      run_mem(1, 32'h0);
      chk("sb_sel", 32'(s_sel), 32'b0001);
      chk("sb_data", s_data, 32'hABAB_ABAB);
      tick();

      set_op(EXE_LH_OP, 32'h5002, 32'h0);
      run_mem(0, 32'h1234_8001);
      chk("lh_sel", 32'(s_sel), 32'b0011);
      chk("lh_wdata", wdata_o, 32'hFFFF_8001);
      tick();
      set_op(EXE_LHU_OP, 32'h5000, 32'h0);
      run_mem(0, 32'h1234_8001);
      chk("lhu_sel", 32'(s_sel), 32'b1100);
      chk("lhu_wdata", wdata_o, 32'h0000_1234);
      tick();

      set_op(EXE_LW_OP, 32'h3001, 32'h0);
      #1;
      chk("lw_mis_align", 32'(align_err_o), 32'd1);
      chk("lw_mis_wreg", 32'(wreg_o), 32'd0);
      chk("lw_mis_stall", 32'(stallreq_o), 32'd0);
      tick();
      chk("lw_mis_req", 32'(bus_if.mem_req_o), 32'd0);
      set_op(EXE_SH_OP, 32'h3001, 32'h0);
      #1;
      chk("sh_mis_align", 32'(align_err_o), 32'd1);
      chk("sh_mis_stall", 32'(stallreq_o), 32'd0);
      tick();
      chk("sh_mis_req", 32'(bus_if.mem_req_o), 32'd0);

      set_op(EXE_LW_OP, 32'h4000, 32'h0);
      run_mem(1000, 32'h0);
      chk("tmo_reqs", 32'(s_reqs), 32'd16);
      chk("tmo_buserr", 32'(bus_err_o), 32'd1);
      chk("tmo_wreg", 32'(wreg_o), 32'd0);
      tick();
      set_op(EXE_OR_OP, 32'h0, 32'h0);
      #1;
      chk("tmo_buserr_clr", 32'(bus_err_o), 32'd0);
      tick();

      set_op(EXE_LW_OP, 32'h4000, 32'h0);
      run_mem(15, 32'hCAFE_F00D);
      chk("late_reqs", 32'(s_reqs), 32'd16);
      chk("late_buserr", 32'(bus_err_o), 32'd0);
      chk("late_wdata", wdata_o, 32'hCAFE_F00D);
      chk("late_wreg", 32'(wreg_o), 32'd1);
      tick();

      set_op(EXE_LW_OP, 32'h7000, 32'h0);
      tick();
      chk("mid_req_on", 32'(bus_if.mem_req_o), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_req_off", 32'(bus_if.mem_req_o), 32'd0);
      chk("mid_stall_off", 32'(stallreq_o), 32'd0);
      bus_if.mem_ack_i  = 1'b1;
      bus_if.mem_data_i = 32'h1111_1111;
      tick();
      bus_if.mem_ack_i = 1'b0;
      rst = 1'b1;
      run_mem(1, 32'h0BAD_F00D);
      chk("post_stalls", 32'(s_stalls), 32'd3);
      chk("post_wdata", wdata_o, 32'h0BAD_F00D);
      chk("post_wreg", 32'(wreg_o), 32'd1);
      tick();
      set_op(EXE_OR_OP, 32'h0, 32'h0);
      tick();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
